// File: rtl/mips_fetch_queue.sv
// Purpose : MIPS instruction-fetch stage; owns the PC, reads a combinational ROM and
//           buffers {instr, pc+PC_INC} in a DEPTH-entry prefetch FIFO in front of ID.
// Latency : fetch in cycle N is visible at id_* in N+1 (empty queue); a redirect target
//           is valid two cycles after redirect is asserted.
// Backpressure: id_ready=0 stalls ID; the queue fills to DEPTH and then the PC holds.
// Ports   : clk/reset (sync, active-high) | imem_addr/imem_data (ROM, same-cycle data)
//           redirect/redirect_pc (taken branch from MEM, flushes the queue)
//           id_valid/id_ready/id_instr/id_pc4 (head entry to ID) | occupancy (entries held)
module mips_fetch_queue #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(4)
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [WIDTH-1:0]           imem_addr,
   input  logic [WIDTH-1:0]           imem_data,
   input  logic                       redirect,
   input  logic [WIDTH-1:0]           redirect_pc,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [WIDTH-1:0]           id_instr,
   output logic [WIDTH-1:0]           id_pc4,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] r_pc;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_occ;
   logic [WIDTH-1:0] r_instr_q [DEPTH];
   logic [WIDTH-1:0] r_pc4_q   [DEPTH];

   logic             w_valid;
   logic             w_pop;
   logic             w_push;
   logic [WIDTH-1:0] w_pc4;

   assign w_valid = (r_occ != '0);
   assign w_pop   = w_valid & id_ready;
   // A full queue still accepts a fetch when the head leaves in the same cycle,
   // which is what keeps the stream gap-free when ID releases a stall.
   assign w_push  = ~redirect & ((r_occ < OCC_FULL) | w_pop);
   assign w_pc4   = r_pc + PC_INC;

   // Pointers, occupancy and PC. Redirect flushes everything and wins over
   // push/pop; a pop offered in the redirect cycle is dropped with the flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (redirect) begin
         r_pc     <= redirect_pc;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_pc     <= w_pc4;
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Entry storage; contents behind the pointers are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_instr_q[r_wr_ptr] <= imem_data;
         r_pc4_q[r_wr_ptr]   <= w_pc4;
      end
   end

   assign imem_addr = r_pc;
   assign id_valid  = w_valid;
   // An empty queue shows a nop rather than stale storage.
   assign id_instr  = w_valid ? r_instr_q[r_rd_ptr] : '0;
   assign id_pc4    = w_valid ? r_pc4_q[r_rd_ptr]   : '0;
   assign occupancy = r_occ;

endmodule

// File: tb/tb_mips_fetch_queue.sv
module tb_mips_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;

   logic [31:0] imem_addr, imem_data;
   logic        id_valid;
   logic [31:0] id_instr, id_pc4;
   logic [2:0]  occupancy;

   logic [31:0] w_imem_addr, w_imem_data;
   logic        w_id_valid;
   logic [31:0] w_id_instr, w_id_pc4;
   logic [2:0]  w_occupancy;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] sb [$];

   always #5 clk = ~clk;

   // ROM model: word i holds i+1
   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign imem_data   = rom(imem_addr);
   assign w_imem_data = rom(w_imem_addr);

   mips_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(32'd4)) u_dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .occupancy(occupancy));

   mips_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_INC(32'd4)) u_wrap (
      .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc4(w_id_pc4), .occupancy(w_occupancy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected stream from a fetch address: {rom(a), a+4} per entry
   task automatic sb_load(input logic [31:0] start, input int n);
      sb.delete();
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = start + 32'(4 * i);
         sb.push_back({rom(a), a + 32'd4});
      end
   endtask

   // Compare any handshake that will commit at the coming edge, then advance one cycle
   task automatic tick();
      if (id_valid && id_ready && !redirect && !reset) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", id_instr, 32'hDEAD_BEEF);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("sb_instr", id_instr, e[63:32]);
            chk("sb_pc4", id_pc4, e[31:0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", id_instr, 32'h0);
      chk("rst_pc4", id_pc4, 32'h0);
      chk("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFF8);

      // Streaming with ID always ready
      reset = 1'b0; id_ready = 1'b1;
      sb_load(32'h0, 64);
      tick();
      chk("first_valid", 32'(id_valid), 32'd1);
      chk("first_instr", id_instr, 32'd1);
      chk("first_pc4", id_pc4, 32'd4);
      chk("wrap_pc4_1", w_id_pc4, 32'hFFFF_FFFC);
      chk("wrap_addr_1", w_imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc4_2", w_id_pc4, 32'h0);
      chk("wrap_addr_2", w_imem_addr, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      chk("steady_occ", 32'(occupancy), 32'd1);
      chk("steady_valid", 32'(id_valid), 32'd1);

      // Stall for six cycles from a fresh reset
      reset = 1'b1; id_ready = 1'b0;
      tick();
      reset = 1'b0;
      sb_load(32'h0, 64);
      for (int i = 0; i < 6; i++) tick();
      chk("stall_occ", 32'(occupancy), 32'd4);
      chk("stall_addr", imem_addr, 32'd16);
      chk("stall_head", id_instr, 32'd1);

      // Release: 1..5 back to back
      id_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("release_valid", 32'(id_valid), 32'd1);
         tick();
      end
      id_ready = 1'b0;
      chk("release_occ", 32'(occupancy), 32'd4);
      chk("release_addr", imem_addr, 32'd36);

      // Single-cycle pop from a full queue
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk("pulse_occ", 32'(occupancy), 32'd4);
      chk("pulse_addr", imem_addr, 32'd40);
      chk("pulse_head", id_instr, 32'd7);

      // Redirect with three entries queued and ID ready
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("pre_redir_occ", 32'(occupancy), 32'd3);
      id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("redir_valid", 32'(id_valid), 32'd0);
      chk("redir_occ", 32'(occupancy), 32'd0);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_instr_nop", id_instr, 32'h0);
      sb_load(32'h100, 32);
      tick();
      chk("tgt_valid", 32'(id_valid), 32'd1);
      chk("tgt_instr", id_instr, rom(32'h100));
      chk("tgt_pc4", id_pc4, 32'h104);
      for (int i = 0; i < 3; i++) tick();

      // Reset overrides a concurrent redirect on a full queue
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("prereset_occ", 32'(occupancy), 32'd4);
      reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      chk("midrst_addr", imem_addr, 32'h0);
      chk("midrst_occ", 32'(occupancy), 32'd0);
      chk("midrst_valid", 32'(id_valid), 32'd0);
      reset = 1'b0; redirect = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
